// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_arbiter
//  Purpose  : Shares one single-port, 1-cycle-latency pixel BRAM among the
//             XVGA scan-out reader (absolute priority), a host pixel writer
//             and a host pixel reader (round-robin between the two hosts).
//             All memory-side signals are registered; read data returns a
//             fixed 3 cycles after the request is accepted.
//  Revision : 1.0  initial release
//
//  Optional feature macro: FB_ARB_VBLANK_WRITE_EN
//    defined   -> host writes are grantable only while vblank=1
//    undefined -> vblank is ignored
//
//  Ports:
//    clk, rst_n                 clock, asynchronous active-low reset
//    vid_req/vid_addr           scan-out read request and address
//    vid_data/vid_data_valid    scan-out pixel return and 1-cycle pulse
//    wr_valid/wr_ready          host write handshake
//    wr_addr/wr_data            host write address and pixel
//    rd_valid/rd_ready          host read handshake
//    rd_addr                    host read address
//    rd_data/rd_data_valid      host read pixel return and 1-cycle pulse
//    vblank                     vertical blank flag (optional feature only)
//    stat_clr                   synchronous clear of host_stall_cnt
//    host_stall_cnt             saturating count of host-stalled cycles
//    mem_en/mem_we/mem_addr/mem_din/mem_dout   BRAM port
// ============================================================================
module fb_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_data_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    input  logic              vblank,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  host_stall_cnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    // Access tag carried alongside each memory access
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_WR   = 2'd2,
        TAG_RD   = 2'd3
    } tag_e;

    // Round-robin state: which host was granted most recently
    typedef enum logic [0:0] {
        HOST_WR = 1'b0,
        HOST_RD = 1'b1
    } host_e;

    host_e             last_host_q, last_host_d;
    tag_e              stage1_q, stage1_d;
    tag_e              stage2_q, stage2_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              vid_data_valid_q, vid_data_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_data_valid_q, rd_data_valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    tag_e              w_grant;
    logic              w_wr_eligible;
    logic              w_stall;

`ifdef FB_ARB_VBLANK_WRITE_EN
    // Writes outside vertical blank are treated as not requesting, so the
    // round-robin never hands them a slot they could not use.
    assign w_wr_eligible = wr_valid & vblank;
`else
    logic  w_unused_vblank;
    assign w_unused_vblank = vblank;
    assign w_wr_eligible   = wr_valid;
`endif

    // ------------------------------------------------------------------
    // Grant decision (combinational) and round-robin next state
    // ------------------------------------------------------------------
    always_comb begin
        w_grant     = TAG_NONE;
        last_host_d = last_host_q;

        // While reset is asserted nothing is granted, so the handshake
        // outputs read 0 along with everything else.
        if (!rst_n) begin
            w_grant = TAG_NONE;
        end else if (vid_req) begin
            w_grant = TAG_VID;
        end else if (w_wr_eligible && rd_valid) begin
            w_grant = (last_host_q == HOST_RD) ? TAG_WR : TAG_RD;
        end else if (w_wr_eligible) begin
            w_grant = TAG_WR;
        end else if (rd_valid) begin
            w_grant = TAG_RD;
        end

        if (w_grant == TAG_WR) begin
            last_host_d = HOST_WR;
        end else if (w_grant == TAG_RD) begin
            last_host_d = HOST_RD;
        end
    end

    assign wr_ready = (w_grant == TAG_WR);
    assign rd_ready = (w_grant == TAG_RD);
    assign w_stall  = (wr_valid | rd_valid) & ~(wr_ready | rd_ready);

    // ------------------------------------------------------------------
    // Memory-side request, tag pipeline, read return and stall counter
    // ------------------------------------------------------------------
    always_comb begin
        mem_en_d   = (w_grant != TAG_NONE);
        mem_we_d   = (w_grant == TAG_WR);
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;

        case (w_grant)
            TAG_VID: mem_addr_d = vid_addr;
            TAG_RD:  mem_addr_d = rd_addr;
            TAG_WR: begin
                mem_addr_d = wr_addr;
                mem_din_d  = wr_data;
            end
            default: mem_addr_d = mem_addr_q;
        endcase

        // Writes produce no return data, so they ride the pipeline as NONE.
        stage1_d = (w_grant == TAG_WR) ? TAG_NONE : w_grant;
        stage2_d = stage1_q;

        // stage2 lines up with the cycle in which mem_dout carries the data.
        vid_data_valid_d = (stage2_q == TAG_VID);
        rd_data_valid_d  = (stage2_q == TAG_RD);
        vid_data_d       = (stage2_q == TAG_VID) ? mem_dout : vid_data_q;
        rd_data_d        = (stage2_q == TAG_RD)  ? mem_dout : rd_data_q;

        stall_cnt_d = stall_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_host_q      <= HOST_RD;
            stage1_q         <= TAG_NONE;
            stage2_q         <= TAG_NONE;
            mem_en_q         <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_din_q        <= '0;
            vid_data_q       <= '0;
            vid_data_valid_q <= 1'b0;
            rd_data_q        <= '0;
            rd_data_valid_q  <= 1'b0;
            stall_cnt_q      <= '0;
        end else begin
            last_host_q      <= last_host_d;
            stage1_q         <= stage1_d;
            stage2_q         <= stage2_d;
            mem_en_q         <= mem_en_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_din_q        <= mem_din_d;
            vid_data_q       <= vid_data_d;
            vid_data_valid_q <= vid_data_valid_d;
            rd_data_q        <= rd_data_d;
            rd_data_valid_q  <= rd_data_valid_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign mem_en         = mem_en_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_din        = mem_din_q;
    assign vid_data       = vid_data_q;
    assign vid_data_valid = vid_data_valid_q;
    assign rd_data        = rd_data_q;
    assign rd_data_valid  = rd_data_valid_q;
    assign host_stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_arbiter
//  Purpose  : Self-checking bench for fb_arbiter with a read-first,
//             1-cycle-latency BRAM model preloaded with data = address.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fb_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 12;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_data_valid;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              vblank;
    logic              stat_clr;
    logic [CNT_W-1:0]  host_stall_cnt;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    logic              mem_load;
    logic [DATA_W-1:0] mem [0:255];

    int n_tests;
    int n_fail;

    fb_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .vid_req        (vid_req),
        .vid_addr       (vid_addr),
        .vid_data       (vid_data),
        .vid_data_valid (vid_data_valid),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_data_valid  (rd_data_valid),
        .vblank         (vblank),
        .stat_clr       (stat_clr),
        .host_stall_cnt (host_stall_cnt),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port read-first BRAM, 1-cycle read latency
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= DATA_W'(i);
            mem_dout <= '0;
        end else if (mem_en) begin
            mem_dout <= mem[mem_addr[7:0]];
            if (mem_we) mem[mem_addr[7:0]] <= mem_din;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic vid;
        logic wr;
        logic rd;
        logic exp_wr_rdy;
        logic exp_rd_rdy;
        logic exp_en;   // mem_en seen this row (from previous row's grant)
        logic exp_we;   // mem_we seen this row
    } vec_t;

    vec_t vecs [0:12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        vid_req  = 1'b0;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        stat_clr = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        mem_load = 1'b1;
        vid_req  = 1'b0;
        vid_addr = '0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_valid = 1'b0;
        rd_addr  = '0;
        vblank   = 1'b1;
        stat_clr = 1'b0;

        // {vid, wr, rd, exp_wr_rdy, exp_rd_rdy, exp_en, exp_we}
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // tie, WR first
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // VID wins
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // last still RD
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // held RD through VID/NONE

        // ---------------- reset state ----------------
        tick();
        tick();
        settle();
        chk("rst_mem_en",   {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we",   {31'd0, mem_we}, 32'd0);
        chk("rst_vid_vld",  {31'd0, vid_data_valid}, 32'd0);
        chk("rst_rd_vld",   {31'd0, rd_data_valid}, 32'd0);
        chk("rst_stall",    32'(host_stall_cnt), 32'd0);
        tick();
        mem_load = 1'b0;
        rst_n    = 1'b1;

        // ---------------- table-driven grant / handshake ----------------
        vid_addr = 16'd20;
        rd_addr  = 16'd10;
        wr_addr  = 16'd50;
        wr_data  = 12'h123;
        for (int i = 0; i < 13; i++) begin
            tick();
            vid_req  = vecs[i].vid;
            wr_valid = vecs[i].wr;
            rd_valid = vecs[i].rd;
            settle();
            chk($sformatf("tbl%0d_wr_ready", i), {31'd0, wr_ready}, {31'd0, vecs[i].exp_wr_rdy});
            chk($sformatf("tbl%0d_rd_ready", i), {31'd0, rd_ready}, {31'd0, vecs[i].exp_rd_rdy});
            chk($sformatf("tbl%0d_mem_en", i),   {31'd0, mem_en},   {31'd0, vecs[i].exp_en});
            chk($sformatf("tbl%0d_mem_we", i),   {31'd0, mem_we},   {31'd0, vecs[i].exp_we});
        end
        tick();
        idle_inputs();
        settle();
        chk("tbl_stall_cnt", 32'(host_stall_cnt), 32'd2);
        chk("tbl_last_we",   {31'd0, mem_we}, 32'd1);
        chk("tbl_last_din",  32'(mem_din), 32'h123);
        repeat (4) tick();

        // ---------------- reset mid-stream ----------------
        tick();
        vid_req  = 1'b1;
        vid_addr = 16'd0;
        tick();
        vid_addr = 16'd1;
        #1;
        rst_n = 1'b0;
        #1;
        vid_req = 1'b0;
        #1;
        chk("mrst_mem_en",  {31'd0, mem_en}, 32'd0);
        chk("mrst_mem_din", 32'(mem_din), 32'd0);
        chk("mrst_rd_data", 32'(rd_data), 32'd0);
        chk("mrst_stall",   32'(host_stall_cnt), 32'd0);
        chk("mrst_ready",   {30'd0, wr_ready, rd_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            settle();
            chk($sformatf("mrst_no_vid_vld%0d", k), {31'd0, vid_data_valid}, 32'd0);
        end
        tick();
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        wr_addr  = 16'd70;
        wr_data  = 12'h789;
        settle();
        chk("mrst_tie_wr", {31'd0, wr_ready}, 32'd1);
        chk("mrst_tie_rd", {31'd0, rd_ready}, 32'd0);
        tick();
        idle_inputs();
        settle();
        chk("mrst_we_next", {31'd0, mem_we}, 32'd1);

        // ---------------- VID priority ----------------
        tick();
        stat_clr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            stat_clr = 1'b0;
            vid_req  = 1'b1;
            vid_addr = 16'd30;
            wr_valid = 1'b1;
            wr_addr  = 16'd60;
            wr_data  = 12'h456;
            settle();
            chk($sformatf("prio_wr_held%0d", k), {31'd0, wr_ready}, 32'd0);
        end
        tick();
        vid_req = 1'b0;
        settle();
        chk("prio_wr_accept", {31'd0, wr_ready}, 32'd1);
        chk("prio_stall10",   32'(host_stall_cnt), 32'd10);
        tick();
        idle_inputs();
        settle();
        chk("prio_mem_we",   {31'd0, mem_we}, 32'd1);
        chk("prio_mem_addr", 32'(mem_addr), 32'd60);
        chk("prio_mem_din",  32'(mem_din), 32'h456);

        // ---------------- round-robin (last host = WR) ----------------
        rd_addr = 16'd10;
        wr_addr = 16'd200;
        wr_data = 12'h0F0;
        for (int k = 0; k < 12; k++) begin
            tick();
            wr_valid = (k < 8);
            rd_valid = (k < 8);
            settle();
            if (k < 8) begin
                chk($sformatf("rr_wr%0d", k), {31'd0, wr_ready}, {31'd0, k[0]});
                chk($sformatf("rr_rd%0d", k), {31'd0, rd_ready}, {31'd0, ~k[0]});
            end
            chk($sformatf("rr_vld%0d", k), {31'd0, rd_data_valid},
                (k == 3 || k == 5 || k == 7 || k == 9) ? 32'd1 : 32'd0);
            if (k == 3 || k == 9) chk($sformatf("rr_data%0d", k), 32'(rd_data), 32'd10);
        end

        // ---------------- latency / throughput ----------------
        for (int k = 0; k < 12; k++) begin
            tick();
            vid_req  = (k < 8);
            vid_addr = ADDR_W'(k);
            settle();
            chk($sformatf("lat_vld%0d", k), {31'd0, vid_data_valid},
                (k >= 3 && k <= 10) ? 32'd1 : 32'd0);
            if (k >= 3 && k <= 10) chk($sformatf("lat_data%0d", k), 32'(vid_data), 32'(k - 3));
        end

        // ---------------- read-after-write ----------------
        tick();
        wr_valid = 1'b1;
        wr_addr  = 16'd5;
        wr_data  = 12'hABC;
        tick();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 16'd5;
        settle();
        chk("raw_rd_ready", {31'd0, rd_ready}, 32'd1);
        tick();
        rd_valid = 1'b0;
        tick();
        settle();
        chk("raw_vld_early", {31'd0, rd_data_valid}, 32'd0);
        tick();
        settle();
        chk("raw_vld",  {31'd0, rd_data_valid}, 32'd1);
        chk("raw_data", 32'(rd_data), 32'hABC);

        // ---------------- saturation / clear ----------------
        tick();
        stat_clr = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            stat_clr = 1'b0;
            vid_req  = 1'b1;
            wr_valid = 1'b1;
        end
        tick();
        stat_clr = 1'b1;
        settle();
        chk("sat_cnt15", 32'(host_stall_cnt), 32'd15);
        tick();
        stat_clr = 1'b0;
        settle();
        chk("sat_clr_wins", 32'(host_stall_cnt), 32'd0);
        tick();
        idle_inputs();
        settle();
        chk("sat_restart", 32'(host_stall_cnt), 32'd1);

        // ---------------- vblank gating ----------------
        tick();
        vblank   = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 16'd90;
        settle();
`ifdef FB_ARB_VBLANK_WRITE_EN
        chk("vb_wr_held", {31'd0, wr_ready}, 32'd0);
`else
        chk("vb_wr_ignored", {31'd0, wr_ready}, 32'd1);
`endif
        tick();
        rd_valid = 1'b1;
        settle();
        chk("vb_rd_ok", {31'd0, rd_ready}, 32'd1);
        chk("vb_wr_no", {31'd0, wr_ready}, 32'd0);
        tick();
        rd_valid = 1'b0;
        vblank   = 1'b1;
        settle();
        chk("vb_wr_accept", {31'd0, wr_ready}, 32'd1);
        tick();
        idle_inputs();
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
